rv_dmem: RTL and testbench

Data-memory responder for the RV32I pipelined core. It sits on the far side of the core's data-memory port and serves loads and stores from the MEM stage:
- combinational read
- synchronous byte/half/word write
- load alignment and sign/zero extension
- a small memory-mapped test region (tohost, 64-bit cycle counter, status)

It replaces the bare testbench RAM and gives simulation a defined completion and error signal.

---
 rtl/rv_dmem.sv | 168 ++++++++++++++++
 tb/tb_rv_dmem.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_dmem.sv
// Data-memory responder for the RV32I core: combinational load path,
// byte/half/word stores and a small tohost/cycle/status window.
`ifndef XLEN
`define XLEN 32
`endif

module rv_dmem #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
  parameter string       INIT_FILE   = ""
) (
  input  logic               i_dmem_clk,
  input  logic               i_dmem_rst,
  input  logic [`XLEN-1:0]   i_dmem_a,
  input  logic [`XLEN-1:0]   i_dmem_wd,
  input  logic               i_dmem_we,
  input  logic [2:0]         i_dmem_bytectrl,
  output logic [`XLEN-1:0]   o_dmem_rd,
  output logic [31:0]        o_dmem_tohost,
  output logic               o_dmem_done,
  output logic               o_dmem_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] tohost;
  logic        done;
  logic        err;
  logic [63:0] cycle;

  logic          is_mmio;
  logic          in_ram;
  logic          bc_ok;
  logic          bc_align;
  logic          acc_err;
  logic [AW-1:0] widx;
  logic [31:0]   word;
  logic [7:0]    lane8;
  logic [15:0]   lane16;
  logic [31:0]   ram_rd;
  logic [31:0]   mmio_rd;
  logic          wr_ok;
  logic          ram_we;
  logic          mmio_we;
  logic [3:0]    be;
  logic [31:0]   wdata;

  assign is_mmio = i_dmem_a[31:4] == MMIO_BASE[31:4];
  assign in_ram  = !is_mmio &&
                   ({2'b00, i_dmem_a[31:2]} < 32'(DEPTH_WORDS));

  // 100/101 are loads only; as stores they are rejected.
  always_comb begin
    bc_ok    = 1'b0;
    bc_align = 1'b1;
    case (i_dmem_bytectrl)
      3'b000: bc_ok = 1'b1;
      3'b001: begin
        bc_ok    = 1'b1;
        bc_align = !i_dmem_a[0];
      end
      3'b010: begin
        bc_ok    = 1'b1;
        bc_align = i_dmem_a[1:0] == 2'b00;
      end
      3'b100: bc_ok = !i_dmem_we;
      3'b101: begin
        bc_ok    = !i_dmem_we;
        bc_align = !i_dmem_a[0];
      end
      default: bc_ok = 1'b0;
    endcase
  end

  assign acc_err = is_mmio ? (i_dmem_bytectrl != 3'b010)
                           : (!in_ram || !bc_ok || !bc_align);

  assign widx   = i_dmem_a[AW+1:2];
  assign word   = mem[widx];
  assign lane8  = word[8*i_dmem_a[1:0] +: 8];
  assign lane16 = i_dmem_a[1] ? word[31:16] : word[15:0];

  always_comb begin
    ram_rd = 32'h0;
    case (i_dmem_bytectrl)
      3'b000:  ram_rd = {{24{lane8[7]}}, lane8};
      3'b100:  ram_rd = {24'h0, lane8};
      3'b001:  ram_rd = {{16{lane16[15]}}, lane16};
      3'b101:  ram_rd = {16'h0, lane16};
      3'b010:  ram_rd = word;
      default: ram_rd = 32'h0;
    endcase
  end

  always_comb begin
    mmio_rd = 32'h0;
    unique case (i_dmem_a[3:2])
      2'd0: mmio_rd = tohost;
      2'd1: mmio_rd = cycle[31:0];
      2'd2: mmio_rd = cycle[63:32];
      2'd3: mmio_rd = {30'h0, err, done};
    endcase
  end

  always_comb begin
    o_dmem_rd = 32'h0;
    if (!acc_err)
      o_dmem_rd = is_mmio ? mmio_rd : ram_rd;
  end

  assign wr_ok   = i_dmem_we && !acc_err && !i_dmem_rst;
  assign ram_we  = wr_ok && in_ram;
  assign mmio_we = wr_ok && is_mmio;

  // Store data is replicated across lanes; enables pick the target.
  always_comb begin
    be    = 4'b0000;
    wdata = i_dmem_wd;
    case (i_dmem_bytectrl[1:0])
      2'b00: begin
        be    = 4'b0001 << i_dmem_a[1:0];
        wdata = {4{i_dmem_wd[7:0]}};
      end
      2'b01: begin
        be    = i_dmem_a[1] ? 4'b1100 : 4'b0011;
        wdata = {2{i_dmem_wd[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge i_dmem_clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_dmem_clk) begin
    if (i_dmem_rst) begin
      tohost <= 32'h0;
      done   <= 1'b0;
      err    <= 1'b0;
      cycle  <= 64'h0;
    end else begin
      if (!done)
        cycle <= cycle + 64'd1;
      if (mmio_we && i_dmem_a[3:2] == 2'd0) begin
        tohost <= i_dmem_wd;
        done   <= 1'b1;
      end
      if (acc_err)
        err <= 1'b1;
      else if (mmio_we && i_dmem_a[3:2] == 2'd3 && i_dmem_wd[1])
        err <= 1'b0;
    end
  end

  assign o_dmem_tohost = tohost;
  assign o_dmem_done   = done;
  assign o_dmem_err    = err;

endmodule

// File: tb/tb_rv_dmem.sv
// Bench for rv_dmem: directed vector table, cycle/reset sequences and
// randomized traffic against a byte-array reference model.
module tb_rv_dmem;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] MB    = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] wd;
  logic        we;
  logic [2:0]  bc;
  logic [31:0] rd;
  logic [31:0] tohost;
  logic        done;
  logic        err;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  rv_dmem #(
    .DEPTH_WORDS(DEPTH),
    .MMIO_BASE  (MB),
    .INIT_FILE  ("")
  ) dut (
    .i_dmem_clk     (clk),
    .i_dmem_rst     (rst),
    .i_dmem_a       (a),
    .i_dmem_wd      (wd),
    .i_dmem_we      (we),
    .i_dmem_bytectrl(bc),
    .o_dmem_rd      (rd),
    .o_dmem_tohost  (tohost),
    .o_dmem_done    (done),
    .o_dmem_err     (err)
  );

  logic [7:0]      m_mem [0:4*DEPTH-1];
  logic [31:0]     m_tohost;
  bit              m_done;
  bit              m_err;
  longint unsigned m_cyc;

  function automatic bit m_mmio(input logic [31:0] ad);
    return (ad >> 4) == (MB >> 4);
  endfunction

  function automatic bit m_bad(input logic [31:0] ad, input logic [2:0] c,
                               input logic w);
    if (m_mmio(ad)) return c != 3'd2;
    if ((ad >> 2) >= DEPTH) return 1'b1;
    case (c)
      3'd0: return 1'b0;
      3'd1: return (ad % 2) != 0;
      3'd2: return (ad % 4) != 0;
      3'd4: return w;
      3'd5: return w || (ad % 2) != 0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] ad,
                                      input logic [2:0] c, input logic w);
    int unsigned n;
    logic [31:0] v;
    if (m_bad(ad, c, w)) return 32'h0;
    if (m_mmio(ad)) begin
      case ((ad >> 2) % 4)
        0: return m_tohost;
        1: return m_cyc[31:0];
        2: return m_cyc[63:32];
        default: return {30'h0, m_err, m_done};
      endcase
    end
    n = 1 << c[1:0];
    v = 32'h0;
    for (int i = 0; i < int'(n); i++)
      v = v | (32'(m_mem[ad + i]) << (8 * i));
    if (c < 3'd4 && n < 4 && v[8*n-1])
      v = v | ~((n == 1) ? 32'hFF : 32'hFFFF);
    return v;
  endfunction

  function automatic void m_step(input logic [31:0] ad, input logic [31:0] d,
                                 input logic w, input logic [2:0] c,
                                 input logic r);
    bit e;
    int unsigned n;
    if (r) begin
      m_tohost = 32'h0;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_cyc    = 0;
      return;
    end
    e = m_bad(ad, c, w);
    if (!m_done) m_cyc = m_cyc + 1;
    if (e) begin
      m_err = 1'b1;
    end else if (w) begin
      if (m_mmio(ad)) begin
        if ((ad >> 2) % 4 == 0) begin
          m_tohost = d;
          m_done   = 1'b1;
        end else if ((ad >> 2) % 4 == 3 && d[1]) begin
          m_err = 1'b0;
        end
      end else begin
        n = 1 << c[1:0];
        for (int i = 0; i < int'(n); i++)
          m_mem[ad + i] = 8'(d >> (8 * i));
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic [31:0] ad, input logic [31:0] d,
                      input logic w, input logic [2:0] c, input logic r,
                      input bit crd, output logic [31:0] rd_pre);
    a   = ad;
    wd  = d;
    we  = w;
    bc  = c;
    rst = r;
    #1;
    rd_pre = rd;
    if (crd) chk("rd_model", rd, m_rd(ad, c, w));
    @(posedge clk);
    m_step(ad, d, w, c, r);
    #1;
    chk("tohost_model", tohost, m_tohost);
    chk("done_model", 32'(done), 32'(m_done));
    chk("err_model", 32'(err), 32'(m_err));
  endtask

  task automatic idle();
    logic [31:0] x;
    tick(MB + 32'h4, 32'h0, 1'b0, 3'd2, 1'b0, 1'b1, x);
  endtask

  task automatic peek(input logic [31:0] ad, input logic [2:0] c,
                      output logic [31:0] v);
    a  = ad;
    bc = c;
    we = 1'b0;
    #1;
    v = rd;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic [2:0]  bc;
    bit          crd;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] ad, input logic [31:0] d,
                              input logic w, input logic [2:0] c,
                              input bit cr, input logic [31:0] e,
                              input logic ee);
    vec_t v;
    v.a = ad; v.wd = d; v.we = w; v.bc = c;
    v.crd = cr; v.erd = e; v.eerr = ee;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [31:0] x;
    logic [31:0] v;
    logic [31:0] lo;
    logic [31:0] ad;
    logic [2:0]  c;
    logic [31:0] st = MB + 32'hC;

    a = 0; wd = 0; we = 0; bc = 3'd2; rst = 1'b1;
    m_tohost = 0; m_done = 0; m_err = 0; m_cyc = 0;
    for (int i = 0; i < 4 * DEPTH; i++) m_mem[i] = 8'h0;

    tick(MB + 32'h4, 0, 1'b0, 3'd2, 1'b1, 1'b0, x);
    tick(MB, 32'h55, 1'b1, 3'd2, 1'b1, 1'b1, x);
    chk("reset_tohost", tohost, 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_err", 32'(err), 32'h0);

    rst = 1'b0;
    peek(MB + 32'h4, 3'd2, v);
    chk("cycle_first", v, 32'd0);
    for (int i = 0; i < 10; i++) idle();
    peek(MB + 32'h4, 3'd2, v);
    chk("cycle_ten", v, 32'd10);

    dut.cycle = 64'hFFFF_FFFF_FFFF_FFFF;
    m_cyc = 64'hFFFF_FFFF_FFFF_FFFF;
    peek(MB + 32'h8, 3'd2, v);
    chk("cycle_hi_max", v, 32'hFFFF_FFFF);
    idle();
    peek(MB + 32'h8, 3'd2, v);
    chk("cycle_hi_wrap", v, 32'h0);
    peek(MB + 32'h4, 3'd2, v);
    chk("cycle_lo_wrap", v, 32'h0);

    for (int i = 0; i < 256; i++)
      tick(32'(i * 4), $urandom, 1'b1, 3'd2, 1'b0, 1'b0, x);

    tbl.push_back(mk(32'h10, 32'h8899AABB, 1, 3'd2, 0, 0, 0));
    tbl.push_back(mk(32'h11, 0, 0, 3'd0, 1, 32'hFFFFFFAA, 0));
    tbl.push_back(mk(32'h11, 0, 0, 3'd4, 1, 32'h000000AA, 0));
    tbl.push_back(mk(32'h12, 0, 0, 3'd1, 1, 32'hFFFF8899, 0));
    tbl.push_back(mk(32'h12, 0, 0, 3'd5, 1, 32'h00008899, 0));
    tbl.push_back(mk(32'h10, 0, 0, 3'd2, 1, 32'h8899AABB, 0));
    tbl.push_back(mk(32'h10, 0, 0, 3'd0, 1, 32'hFFFFFFBB, 0));
    tbl.push_back(mk(32'h13, 0, 0, 3'd4, 1, 32'h00000088, 0));
    tbl.push_back(mk(32'h10, 0, 0, 3'd5, 1, 32'h0000AABB, 0));
    tbl.push_back(mk(32'h20, 0, 1, 3'd2, 0, 0, 0));
    tbl.push_back(mk(32'h23, 32'h5A, 1, 3'd0, 0, 0, 0));
    tbl.push_back(mk(32'h20, 32'h1234, 1, 3'd1, 0, 0, 0));
    tbl.push_back(mk(32'h20, 0, 0, 3'd2, 1, 32'h5A001234, 0));
    tbl.push_back(mk(32'h21, 0, 0, 3'd1, 1, 32'h0, 1));
    tbl.push_back(mk(st, 32'h2, 1, 3'd2, 1, 32'h2, 0));
    tbl.push_back(mk(32'h22, 32'hFFFFFFFF, 1, 3'd2, 1, 32'h0, 1));
    tbl.push_back(mk(32'h20, 0, 0, 3'd2, 1, 32'h5A001234, 1));
    tbl.push_back(mk(st, 32'h2, 1, 3'd0, 1, 32'h0, 1));
    tbl.push_back(mk(st, 32'h2, 1, 3'd2, 1, 32'h2, 0));
    tbl.push_back(mk(32'h4000, 0, 0, 3'd2, 1, 32'h0, 1));
    tbl.push_back(mk(st, 32'h2, 1, 3'd2, 1, 32'h2, 0));
    tbl.push_back(mk(32'h20, 0, 0, 3'd3, 1, 32'h0, 1));
    tbl.push_back(mk(st, 32'h2, 1, 3'd2, 1, 32'h2, 0));
    tbl.push_back(mk(32'h24, 0, 1, 3'd2, 0, 0, 0));
    tbl.push_back(mk(32'h24, 32'hFF, 1, 3'd4, 1, 32'h0, 1));
    tbl.push_back(mk(st, 32'h2, 1, 3'd2, 1, 32'h2, 0));
    tbl.push_back(mk(32'h24, 0, 0, 3'd2, 1, 32'h0, 0));
    tbl.push_back(mk(32'h13, 0, 0, 3'd5, 1, 32'h0, 1));
    tbl.push_back(mk(st, 32'h0, 1, 3'd2, 1, 32'h2, 1));
    tbl.push_back(mk(st, 32'h2, 1, 3'd2, 1, 32'h2, 0));
    tbl.push_back(mk(MB + 32'h4, 32'h1234, 1, 3'd2, 0, 0, 0));
    tbl.push_back(mk(MB + 32'h10, 0, 0, 3'd2, 1, 32'h0, 1));
    tbl.push_back(mk(st, 32'h2, 1, 3'd2, 1, 32'h2, 0));

    foreach (tbl[i]) begin
      tick(tbl[i].a, tbl[i].wd, tbl[i].we, tbl[i].bc, 1'b0, 1'b1, x);
      if (tbl[i].crd) chk($sformatf("vec%0d_rd", i), x, tbl[i].erd);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].eerr));
    end

    tick(MB, 32'h1, 1'b1, 3'd2, 1'b0, 1'b1, x);
    chk("tohost_set", tohost, 32'h1);
    chk("done_set", 32'(done), 32'h1);
    peek(MB + 32'h4, 3'd2, lo);
    idle();
    idle();
    idle();
    peek(MB + 32'h4, 3'd2, v);
    chk("cycle_frozen", v, lo);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: ad = MB + 32'($urandom_range(0, 15));
        1: ad = 32'h4000 + 32'($urandom_range(0, 255));
        default: ad = 32'($urandom_range(0, 1023));
      endcase
      if ($urandom_range(0, 3) != 0)
        case ($urandom_range(0, 4))
          0: c = 3'd0;
          1: c = 3'd1;
          2: c = 3'd2;
          3: c = 3'd4;
          default: c = 3'd5;
        endcase
      else
        c = 3'($urandom_range(0, 7));
      tick(ad, $urandom, $urandom_range(0, 2) == 0, c, 1'b0, 1'b1, x);
    end

    tick(32'h40, 32'hCAFEF00D, 1'b1, 3'd2, 1'b0, 1'b1, x);
    tick(MB, 32'hDEAD, 1'b1, 3'd2, 1'b0, 1'b1, x);
    tick(32'h4000, 0, 1'b0, 3'd2, 1'b0, 1'b1, x);
    chk("pre_rst_tohost", tohost, 32'hDEAD);
    chk("pre_rst_done", 32'(done), 32'h1);
    chk("pre_rst_err", 32'(err), 32'h1);
    tick(MB, 32'h1234, 1'b1, 3'd2, 1'b1, 1'b1, x);
    chk("rst_tohost", tohost, 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    tick(32'h40, 32'h0, 1'b1, 3'd2, 1'b1, 1'b1, x);
    idle();
    peek(32'h40, 3'd2, v);
    chk("ram_kept", v, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
